regfile_read_stage: RTL

- Decode-stage read side of the 32x32 register file, paired with the per-register write cells that own storage.
- Selects two source operands from the flattened register array, with EX/MEM/WB bypass and a $0 hard-zero.
- Detects load-use hazards and stalls the decode handshake.
- Captures operands into the ID/EX pipeline register behind a valid/ready handshake, and keeps a saturating stall counter.

---
 rtl/regfile_read_stage_pkg.sv | 15 +
 rtl/regfile_read_stage_bypass.sv | 67 ++++++
 rtl/regfile_read_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regfile_read_stage_pkg.sv
// Pipeline definitions shared by the register-file read stage.
// Holds the default widths of the operand datapath, the register
// address and the stall counter, plus the index of the hard-zero
// register ($0).
package regfile_read_stage_pkg;

  localparam int PIPE_DATA_W = 32;  // operand / register width
  localparam int PIPE_NREGS  = 32;  // architectural registers
  localparam int PIPE_ADDR_W = 5;   // log2(PIPE_NREGS)
  localparam int PIPE_CNT_W  = 16;  // stall counter width

  // $0 always reads as zero and is never a bypass target.
  localparam logic [PIPE_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_stage_bypass.sv
// operand_bypass_mux: combinational source-operand select for one
// read port of the register file.
// Ports:
//   addr                       source register index
//   regs_flat                  flattened register array (reg k at k*DATA_W)
//   ex_wen/ex_is_load/ex_waddr/ex_wdata   EX-stage writer
//   mem_wen/mem_waddr/mem_wdata           MEM-stage writer
//   wb_wen/wb_waddr/wb_wdata              WB-stage writer (array not yet updated)
//   operand                    selected value
// Priority: $0, then EX (non-load only), MEM, WB, array.
module operand_bypass_mux
  import regfile_read_stage_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int NREGS  = PIPE_NREGS,
  parameter int ADDR_W = PIPE_ADDR_W
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W*NREGS-1:0] regs_flat,
  input  logic                    ex_wen,
  input  logic                    ex_is_load,
  input  logic [ADDR_W-1:0]       ex_waddr,
  input  logic [DATA_W-1:0]       ex_wdata,
  input  logic                    mem_wen,
  input  logic [ADDR_W-1:0]       mem_waddr,
  input  logic [DATA_W-1:0]       mem_wdata,
  input  logic                    wb_wen,
  input  logic [ADDR_W-1:0]       wb_waddr,
  input  logic [DATA_W-1:0]       wb_wdata,
  output logic [DATA_W-1:0]       operand
);

  // Unpack the flat bus so the array read is a plain indexed select.
  logic [DATA_W-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_unpack
      assign regs[gi] = regs_flat[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic is_zero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign is_zero = (addr == ADDR_W'(REG_ZERO));
  // A load in EX has no result yet; the hazard logic stalls instead.
  assign ex_hit  = ex_wen && !ex_is_load && (ex_waddr == addr);
  assign mem_hit = mem_wen && (mem_waddr == addr);
  assign wb_hit  = wb_wen && (wb_waddr == addr);

  always_comb begin
    operand = regs[addr];
    if (is_zero) begin
      operand = '0;
    end else if (ex_hit) begin
      operand = ex_wdata;
    end else if (mem_hit) begin
      operand = mem_wdata;
    end else if (wb_hit) begin
      operand = wb_wdata;
    end
  end

endmodule

// File: rtl/regfile_read_stage.sv
// regfile_read_stage: decode-side read of the register file.
// Selects two operands (with EX/MEM/WB bypass), detects load-use
// hazards, and captures operands into the ID/EX register behind a
// valid/ready handshake. Counts hazard-stall cycles (saturating).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   regs_flat              register array contents
//   in_valid / in_ready    decode-side handshake
//   rs_addr, rt_addr       source indices; use_rs/use_rt qualify them
//   ex_*, mem_*, wb_*      bypass sources from later stages
//   out_valid / out_ready  EX-side handshake
//   op_a, op_b             registered operands
//   hazard                 combinational load-use stall
//   stall_count            saturating count of stalled request cycles
module regfile_read_stage
  import regfile_read_stage_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int NREGS  = PIPE_NREGS,
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W*NREGS-1:0] regs_flat,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       rs_addr,
  input  logic [ADDR_W-1:0]       rt_addr,
  input  logic                    use_rs,
  input  logic                    use_rt,
  input  logic                    ex_wen,
  input  logic                    ex_is_load,
  input  logic [ADDR_W-1:0]       ex_waddr,
  input  logic [DATA_W-1:0]       ex_wdata,
  input  logic                    mem_wen,
  input  logic [ADDR_W-1:0]       mem_waddr,
  input  logic [DATA_W-1:0]       mem_wdata,
  input  logic                    wb_wen,
  input  logic [ADDR_W-1:0]       wb_waddr,
  input  logic [DATA_W-1:0]       wb_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  output logic                    hazard,
  output logic [CNT_W-1:0]        stall_count
);

  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  logic              out_valid_reg;
  logic [DATA_W-1:0] op_a_reg;
  logic [DATA_W-1:0] op_b_reg;
  logic [CNT_W-1:0]  stall_count_reg;

  logic advance;
  logic load_in_ex;
  logic accept;

  operand_bypass_mux #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)
  ) u_mux_a (
    .addr(rs_addr), .regs_flat(regs_flat),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .operand(sel_a)
  );

  operand_bypass_mux #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)
  ) u_mux_b (
    .addr(rt_addr), .regs_flat(regs_flat),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .operand(sel_b)
  );

  // A load targeting $0 produces nothing anyone can observe, so it never stalls.
  assign load_in_ex = ex_wen && ex_is_load && (ex_waddr != ADDR_W'(REG_ZERO));
  assign hazard     = load_in_ex &&
                      ((use_rs && (rs_addr == ex_waddr)) ||
                       (use_rt && (rt_addr == ex_waddr)));

  // The ID/EX slot can be refilled when it is empty or being drained.
  assign advance  = out_ready || !out_valid_reg;
  assign in_ready = advance && !hazard;
  assign accept   = in_valid && !hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
    end else if (advance) begin
      if (accept) begin
        out_valid_reg <= 1'b1;
        op_a_reg      <= sel_a;
        op_b_reg      <= sel_b;
      end else begin
        // Bubble: operands keep their stale values, only valid drops.
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Counts cycles in which a request was blocked by a load-use hazard,
  // regardless of backpressure; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_reg <= '0;
    end else if (in_valid && hazard && (stall_count_reg != '1)) begin
      stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign out_valid   = out_valid_reg;
  assign op_a        = op_a_reg;
  assign op_b        = op_b_reg;
  assign stall_count = stall_count_reg;

endmodule
